spi_slave_core: RTL and testbench

- SPI slave-side engine: the far end of the link driven by the master SCLK generator.
- Oversamples external SCLK/SS_n/MOSI in the system clock domain.
- Detects sample/setup edges per CPOL/CPHA, deserialises MOSI into bytes and serialises a one-entry TX holding register onto MISO.
- Sits beside the master path, selected when i_mstr=0; register-side handshakes go to the AXI register block.

---
 rtl/spi_slave_core_pkg.sv | 17 +
 rtl/spi_slave_sync.sv | 54 +++++
 rtl/spi_slave_core.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_core_pkg.sv
// spi_slave_core shared types and constants.
// FSM encoding, SPI mode codes ({cpol,cpha}) and the default transfer width.
package spi_slave_core_pkg;

   localparam int SPI_DATA_W = 8;

   typedef enum logic {
      SPI_SLV_IDLE   = 1'b0,
      SPI_SLV_ACTIVE = 1'b1
   } slv_state_e;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: synchronises SCLK/SS_n/MOSI into the system clock
// domain and produces registered single-cycle edge strobes.
module spi_slave_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic cpol,
   input  logic sclk,
   input  logic ss_n,
   input  logic mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ss_fall,
   output logic ss_rise,
   output logic mosi_sync
);

   localparam int L = SYNC_STAGES - 1;

   logic [L:0] sclk_q;
   logic [L:0] ss_q;
   logic [L:0] mosi_q;
   logic       sclk_d;
   logic       ss_d;

   // synchroniser chains, edge history and strobe/data output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q    <= {SYNC_STAGES{cpol}};
         ss_q      <= '0;
         mosi_q    <= '0;
         sclk_d    <= cpol;
         ss_d      <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         ss_fall   <= 1'b0;
         ss_rise   <= 1'b0;
         mosi_sync <= 1'b0;
      end else begin
         sclk_q    <= {sclk_q[L-1:0], sclk};
         ss_q      <= {ss_q[L-1:0], ss_n};
         mosi_q    <= {mosi_q[L-1:0], mosi};
         sclk_d    <= sclk_q[L];
         ss_d      <= ss_q[L];
         sclk_rise <= sclk_q[L] & ~sclk_d;
         sclk_fall <= ~sclk_q[L] & sclk_d;
         ss_fall   <= ~ss_q[L] & ss_d;
         ss_rise   <= ss_q[L] & ~ss_d;
         mosi_sync <= mosi_q[L];
      end
   end

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave with RX byte register and TX holding register.
// Optional sticky error flags enabled by defining SPI_SLAVE_ERR_FLAGS_EN.
module spi_slave_core
   import spi_slave_core_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_cpol,
   input  logic              i_cpha,
   input  logic              i_mstr,
   input  logic              i_spi_sclk,
   input  logic              i_spi_ss_n,
   input  logic              i_spi_mosi,
   output logic              o_spi_miso,
   output logic              o_spi_miso_oe,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   input  logic              i_rx_ready,
   output logic              o_busy,
   output logic              o_rx_overrun,
   output logic              o_tx_underrun,
   input  logic              i_flag_clr
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   slv_state_e        state;
   slv_state_e        state_nxt;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              ss_fall;
   logic              ss_rise;
   logic              mosi_s;
   logic              sample;
   logic              setup;
   logic              act;
   logic              frame_end;
   logic              tx_load;
   logic              tx_shift_en;
   logic              tx_wr;
   logic              rx_done;
   logic              ovr_evt;
   logic              unr_evt;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] tx_hold;
   logic              tx_full;

   spi_slave_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (i_clk),
      .reset_n   (i_reset_n),
      .cpol      (i_cpol),
      .sclk      (i_spi_sclk),
      .ss_n      (i_spi_ss_n),
      .mosi      (i_spi_mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .ss_fall   (ss_fall),
      .ss_rise   (ss_rise),
      .mosi_sync (mosi_s)
   );

   // map SCLK strobes onto sample/setup edges for the current mode
   always_comb begin
      sample = 1'b0;
      setup  = 1'b0;
      unique case ({i_cpol, i_cpha})
         SPI_MODE0, SPI_MODE3: begin
            sample = sclk_rise;
            setup  = sclk_fall;
         end
         SPI_MODE1, SPI_MODE2: begin
            sample = sclk_fall;
            setup  = sclk_rise;
         end
      endcase
   end

   // frame state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= SPI_SLV_IDLE;
      else            state <= state_nxt;
   end

   // next state and per-cycle datapath controls
   always_comb begin
      state_nxt = state;
      unique case (state)
         SPI_SLV_IDLE:   if (ss_fall && !i_mstr) state_nxt = SPI_SLV_ACTIVE;
         SPI_SLV_ACTIVE: if (ss_rise || i_mstr)  state_nxt = SPI_SLV_IDLE;
      endcase
      act         = (state == SPI_SLV_ACTIVE) && (state_nxt == SPI_SLV_ACTIVE);
      frame_end   = (state == SPI_SLV_ACTIVE) && (state_nxt == SPI_SLV_IDLE);
      tx_load     = ((state == SPI_SLV_IDLE) && (state_nxt == SPI_SLV_ACTIVE) && !i_cpha)
                    || (act && setup && (bit_cnt == '0));
      tx_shift_en = act && setup && (bit_cnt != '0);
      tx_wr       = i_tx_valid && !tx_full;
      rx_done     = act && sample && (bit_cnt == LAST);
      ovr_evt     = rx_done && o_rx_valid && !i_rx_ready;
      unr_evt     = tx_load && !tx_full;
   end

   // receive shifter, bit counter and RX byte register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bit_cnt    <= '0;
         rx_shift   <= '0;
         o_rx_data  <= '0;
         o_rx_valid <= 1'b0;
      end else begin
         if (frame_end) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
         end else if (act && sample) begin
            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
            bit_cnt  <= rx_done ? '0 : bit_cnt + 1'b1;
         end
         if (rx_done) begin
            o_rx_data  <= {rx_shift[DATA_W-2:0], mosi_s};
            o_rx_valid <= 1'b1;
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

   // transmit shifter and one-entry holding register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         tx_shift <= '0;
         tx_hold  <= '0;
         tx_full  <= 1'b0;
      end else begin
         if (frame_end)        tx_shift <= '0;
         else if (tx_load)     tx_shift <= tx_full ? tx_hold : '0;
         else if (tx_shift_en) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
         if (tx_wr) begin
            tx_hold <= i_tx_data;
            tx_full <= 1'b1;
         end else if (tx_load) begin
            tx_full <= 1'b0;
         end
      end
   end

   assign o_busy        = (state == SPI_SLV_ACTIVE);
   assign o_spi_miso_oe = o_busy;
   assign o_spi_miso    = o_busy & tx_shift[DATA_W-1];
   assign o_tx_ready    = !tx_full;

`ifdef SPI_SLAVE_ERR_FLAGS_EN
   // sticky error flags, a new event beats a simultaneous clear
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rx_overrun  <= 1'b0;
         o_tx_underrun <= 1'b0;
      end else begin
         if (ovr_evt)         o_rx_overrun  <= 1'b1;
         else if (i_flag_clr) o_rx_overrun  <= 1'b0;
         if (unr_evt)         o_tx_underrun <= 1'b1;
         else if (i_flag_clr) o_tx_underrun <= 1'b0;
      end
   end
`else
   logic unused_flags;
   assign unused_flags  = ^{i_flag_clr, ovr_evt, unr_evt};
   assign o_rx_overrun  = 1'b0;
   assign o_tx_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: drives SPI frames as a master would and checks
// received/transmitted bytes and flags against a byte-level model.
module tb_spi_slave_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic       mstr = 1'b0;
   logic       sclk = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic       busy;
   logic       rx_ovr;
   logic       tx_unr;
   logic       flag_clr = 1'b0;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] mo [4];
   logic [7:0] tx [4];
   logic       err_en;

   always #5 clk = ~clk;

   spi_slave_core dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_cpol        (cpol),
      .i_cpha        (cpha),
      .i_mstr        (mstr),
      .i_spi_sclk    (sclk),
      .i_spi_ss_n    (ss_n),
      .i_spi_mosi    (mosi),
      .o_spi_miso    (miso),
      .o_spi_miso_oe (miso_oe),
      .i_tx_data     (tx_data),
      .i_tx_valid    (tx_valid),
      .o_tx_ready    (tx_ready),
      .o_rx_data     (rx_data),
      .o_rx_valid    (rx_valid),
      .i_rx_ready    (rx_ready),
      .o_busy        (busy),
      .o_rx_overrun  (rx_ovr),
      .o_tx_underrun (tx_unr),
      .i_flag_clr    (flag_clr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_write(input logic [7:0] d);
      int t = 0;
      while (!tx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic set_mode(input int m);
      cpol = m[1];
      cpha = m[0];
      sclk = m[1];
      clk_n(8);
   endtask

   // master side of one frame: nb whole bytes followed by extra loose bits
   task automatic run_frame(input int nb, input int extra, input bit consume);
      logic [7:0] got;
      logic       mbit;
      logic       exp_ovr;
      logic       exp_unr;
      int         k;
      int         i;
      flag_clr = 1'b1;
      clk_n(1);
      flag_clr = 1'b0;
      tx_write(tx[0]);
      ss_n = 1'b0;
      clk_n(6);
      got = 8'h00;
      for (int b = 0; b < nb * 8 + extra; b++) begin
         k = b / 8;
         i = b % 8;
         mbit = (k < nb) ? mo[k][7-i] : 1'($urandom);
         if (!cpha) begin
            mosi = mbit;
            clk_n(4);
            got  = {got[6:0], miso};
            sclk = ~sclk;
            clk_n(4);
            sclk = ~sclk;
         end else begin
            sclk = ~sclk;
            mosi = mbit;
            clk_n(4);
            got  = {got[6:0], miso};
            sclk = ~sclk;
            clk_n(4);
         end
         if (k + 1 < nb && i == 0) tx_write(tx[k+1]);
         if (k < nb && i == 7) begin
            clk_n(5);
            check_eq("miso_byte", {24'd0, got}, {24'd0, tx[k]});
            check_eq("rx_data", {24'd0, rx_data}, {24'd0, mo[k]});
            check_eq("rx_valid", {31'd0, rx_valid}, 32'd1);
            if (consume) begin
               rx_ready = 1'b1;
               clk_n(1);
               rx_ready = 1'b0;
               check_eq("rx_valid_clr", {31'd0, rx_valid}, 32'd0);
            end
         end
      end
      ss_n = 1'b1;
      clk_n(6);
      check_eq("busy_end", {31'd0, busy}, 32'd0);
      check_eq("oe_end", {31'd0, miso_oe}, 32'd0);
      check_eq("miso_end", {31'd0, miso}, 32'd0);
      if (extra > 0 && consume)
         check_eq("partial_no_valid", {31'd0, rx_valid}, 32'd0);
      exp_ovr = err_en & !consume & (nb >= 2);
      exp_unr = err_en & (nb > 0) & (!cpha || extra > 0);
      check_eq("rx_overrun", {31'd0, rx_ovr}, {31'd0, exp_ovr});
      check_eq("tx_underrun", {31'd0, tx_unr}, {31'd0, exp_unr});
      flag_clr = 1'b1;
      clk_n(1);
      flag_clr = 1'b0;
      check_eq("flags_clr", {30'd0, rx_ovr, tx_unr}, 32'd0);
      if (!consume && nb > 0) begin
         rx_ready = 1'b1;
         clk_n(1);
         rx_ready = 1'b0;
      end
   endtask

   task automatic rand_bytes(input int nb);
      for (int j = 0; j < nb; j++) begin
         mo[j] = 8'($urandom);
         tx[j] = 8'($urandom);
      end
   endtask

   initial begin
`ifdef SPI_SLAVE_ERR_FLAGS_EN
      err_en = 1'b1;
`else
      err_en = 1'b0;
`endif
      clk_n(5);
      check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check_eq("rst_busy_oe_miso", {29'd0, busy, miso_oe, miso}, 32'd0);
      check_eq("rst_flags", {30'd0, rx_ovr, tx_unr}, 32'd0);
      rst_n = 1'b1;
      clk_n(8);

      for (int m = 0; m < 4; m++) begin
         set_mode(m);
         mo[0] = 8'h3C;
         tx[0] = 8'hA5;
         run_frame(1, 0, 1'b1);
      end

      for (int m = 0; m < 4; m += 3) begin
         set_mode(m);
         mo[0] = 8'($urandom);
         mo[1] = 8'($urandom);
         tx[0] = 8'h11;
         tx[1] = 8'h22;
         run_frame(2, 0, 1'b1);
      end

      for (int r = 0; r < 8; r++) begin
         int nb;
         set_mode(int'($urandom_range(0, 3)));
         nb = int'($urandom_range(1, 3));
         rand_bytes(nb);
         run_frame(nb, 0, 1'b1);
      end

      for (int m = 0; m < 4; m++) begin
         set_mode(m);
         rand_bytes(2);
         run_frame(2, 0, 1'b0);
      end

      for (int m = 0; m < 4; m++) begin
         set_mode(m);
         rand_bytes(1);
         run_frame(0, 5, 1'b1);
         rand_bytes(1);
         run_frame(1, 0, 1'b1);
      end

      set_mode(0);
      mstr = 1'b1;
      ss_n = 1'b0;
      clk_n(8);
      check_eq("mstr_idle", {30'd0, busy, miso_oe}, 32'd0);
      ss_n = 1'b1;
      clk_n(6);
      mstr = 1'b0;

      set_mode(1);
      tx_write(8'h5A);
      ss_n = 1'b0;
      clk_n(6);
      check_eq("mid_busy_oe", {30'd0, busy, miso_oe}, 32'd3);
      check_eq("mid_tx_full", {31'd0, tx_ready}, 32'd0);
      sclk = ~sclk;
      clk_n(6);
      rst_n = 1'b0;
      #1;
      check_eq("arst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check_eq("arst_outs", {28'd0, busy, miso_oe, miso, rx_valid}, 32'd0);
      check_eq("arst_rx_data", {24'd0, rx_data}, 32'd0);
      clk_n(2);
      ss_n = 1'b1;
      sclk = cpol;
      rst_n = 1'b1;
      clk_n(8);
      rand_bytes(1);
      run_frame(1, 0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
